dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous, active-high.
REQ-002 Ports SHALL be:
- MemWrite  input  1  store strobe from the core
- DataAdr  input  32  byte address from the core ALU
- WriteData  input  32  store data
- ReadData  output  32  load data, combinational
- tx_data  output  32  FIFO head word
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  consumer accepts the head word
REQ-003 Parameters SHALL be:
- RAM_WORDS, default 64, number of RAM words
- FIFO_DEPTH, default 4, TX FIFO entries, power of two

Function
REQ-004 The address map SHALL use DataAdr[1:0] ignored (word access only):
- 0x000-0x0FF RAM, indexed by DataAdr[7:2]
- 0x100 TXDATA
- 0x104 STATUS
- 0x108 TXCOUNT
REQ-005 A RAM write SHALL occur on the rising clk edge when MemWrite=1 and the address is in RAM range; RAM reads SHALL be combinational from the current DataAdr.
REQ-006 A write to TXDATA SHALL push WriteData into the FIFO at the clock edge if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-007 A pop SHALL occur at a clock edge when tx_valid=1 and tx_ready=1; tx_data SHALL then present the next entry, or tx_valid SHALL fall if the FIFO becomes empty.
REQ-008 Push into an empty FIFO SHALL raise tx_valid in the cycle after the edge, with tx_data equal to the pushed word (1-cycle latency); no same-cycle bypass.
REQ-009 Simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-010 A push rejected due to full SHALL drop the data, leave the FIFO unchanged and set sticky overflow.
REQ-011 Reads of STATUS SHALL return:
- bit0 full
- bit1 empty
- bits[4:2] count (0..FIFO_DEPTH)
- bit5 overflow
- all other bits 0
REQ-012 Any write to STATUS SHALL clear overflow; if a rejected push could coincide with it, the clear SHALL win (a rejected push and a STATUS write cannot share a cycle, since both need MemWrite at different addresses).
REQ-013 TXCOUNT SHALL increment by 1 on every accepted push, wrap modulo 2^32, and be read-only; writes to it are ignored.
REQ-014 Reads of TXDATA and of unmapped addresses SHALL return 0; writes to unmapped addresses SHALL have no effect.
REQ-015 The FIFO pointers SHALL be log2(FIFO_DEPTH) bits, wrapping naturally; the count SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-016 While reset=1 at a clock edge, the block SHALL set:
- FIFO pointers and count to 0
- overflow to 0
- TXCOUNT to 0
- tx_valid to 0
- tx_data to 0 when empty
REQ-017 Reset SHALL NOT clear RAM contents.
REQ-018 Stores while reset=1 SHALL be ignored for all MMIO registers.
REQ-019 Reset asserted mid-stream SHALL discard all queued FIFO entries at that edge.

Structure
REQ-020 Package dmem_pkg SHALL hold the address constants TXDATA_ADR, STATUS_ADR, TXCOUNT_ADR and RAM_TOP, plus the STATUS bit-position constants.
REQ-021 The FIFO SHALL be a separate sub-module tx_fifo (push/pop/full/empty/count), instantiated once; address decode and RAM stay in dmem_mmio.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- RAM: store 25 to 100, then load 100 -> ReadData=25; store 7 to 96 -> load 96 = 7, load 100 still 25.
- Fill: tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> STATUS = full, count=4, overflow=1; TXCOUNT=4; then tx_ready=1 -> drains 0x11..0x44 in order, one per cycle, then tx_valid=0.
- Full with simultaneous pop: FIFO full, tx_ready=1, push 0x99 -> accepted; count stays 4; 0x99 emerges last; overflow unchanged.
- Latency: empty FIFO, push 0xA5 at edge N -> tx_valid=1 and tx_data=0xA5 after edge N, not before.
- Overflow clear / unmapped: write STATUS -> bit5=0; write 0x200 -> no state change; read 0x200 -> 0.
- Reset mid-stream: 3 entries queued, TXCOUNT=3, reset for 1 cycle -> tx_valid=0, STATUS=0x2, TXCOUNT=0, RAM word at 100 retained.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared address map, STATUS bit layout and address decode for the data-memory/MMIO slice.
// The core's load/store port sees RAM at the bottom of the map and three TX registers above it.
package dmem_pkg;

    localparam logic [31:0] RAM_TOP     = 32'h0000_0100;
    localparam logic [31:0] TXDATA_ADR  = 32'h0000_0100;
    localparam logic [31:0] STATUS_ADR  = 32'h0000_0104;
    localparam logic [31:0] TXCOUNT_ADR = 32'h0000_0108;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_COUNT_LSB = 2;
    localparam int STATUS_COUNT_MSB = 4;
    localparam int STATUS_OVF_BIT   = 5;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_TXDATA,
        REGION_STATUS,
        REGION_TXCOUNT,
        REGION_NONE
    } region_e;

    // Byte lanes are ignored: every access is treated as a whole-word access.
    function automatic region_e decode_region(input logic [31:0] adr);
        logic [31:0] word_adr;
        region_e     region;
        word_adr = {adr[31:2], 2'b00};
        region   = REGION_NONE;
        if (word_adr < RAM_TOP)
            region = REGION_RAM;
        else if (word_adr == TXDATA_ADR)
            region = REGION_TXDATA;
        else if (word_adr == STATUS_ADR)
            region = REGION_STATUS;
        else if (word_adr == TXCOUNT_ADR)
            region = REGION_TXCOUNT;
        return region;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Circular-buffer TX FIFO. A push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle; the head word reads as zero while the FIFO is empty.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the zero-count state already masks stale words.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory with a small MMIO window: word RAM plus a TX FIFO with STATUS and a
// running count of accepted pushes. Loads are combinational from the current address.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int SCW    = STATUS_COUNT_MSB - STATUS_COUNT_LSB + 1;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;

    region_e     region;
    logic        push_req, push_ok, pop, status_wr;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic        overflow_q, overflow_d;
    logic [31:0] txcount_q, txcount_d;
    logic [31:0] status_word;

    assign region    = decode_region(DataAdr);
    assign ram_idx   = DataAdr[RAM_AW+1:2];
    assign ram_we    = MemWrite && (region == REGION_RAM);
    assign push_req  = MemWrite && !reset && (region == REGION_TXDATA);
    assign status_wr = MemWrite && !reset && (region == REGION_STATUS);
    assign pop       = tx_valid && tx_ready;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign tx_valid  = !fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (WriteData),
        .pop       (pop),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A STATUS write clears overflow even if a rejected push were to land in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        txcount_d  = txcount_q;
        if (status_wr)
            overflow_d = 1'b0;
        else if (push_req && !push_ok)
            overflow_d = 1'b1;
        if (push_ok)
            txcount_d = txcount_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            txcount_q  <= '0;
        end else begin
            overflow_q <= overflow_d;
            txcount_q  <= txcount_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram_q[ram_idx] <= WriteData;
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = SCW'(fifo_count);
        status_word[STATUS_OVF_BIT]   = overflow_q;
    end

    // TXDATA and unmapped addresses read back as zero.
    always_comb begin
        ReadData = '0;
        case (region)
            REGION_RAM:     ReadData = ram_q[ram_idx];
            REGION_STATUS:  ReadData = status_word;
            REGION_TXCOUNT: ReadData = txcount_q;
            default:        ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the memory map and TX FIFO.
module tb_dmem_mmio;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit checking     = 0;

    logic [31:0] m_ram [64];
    bit          m_ram_known [64];
    logic [31:0] m_q [$];
    bit          m_ovf;
    logic [31:0] m_txcnt;

    dmem_mmio #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] adr);
        logic [31:0] a;
        int          cnt;
        a   = adr & ~32'h3;
        cnt = m_q.size();
        if (a < 32'h100)
            return m_ram[a[7:2]];
        if (a == 32'h104)
            return 32'((cnt == 4 ? 1 : 0) + 2 * (cnt == 0 ? 1 : 0) + 4 * cnt + 32 * int'(m_ovf));
        if (a == 32'h108)
            return m_txcnt;
        return 32'h0;
    endfunction

    function automatic bit modelKnown(input logic [31:0] adr);
        logic [31:0] a;
        a = adr & ~32'h3;
        if (a < 32'h100)
            return m_ram_known[a[7:2]];
        return 1'b1;
    endfunction

    task automatic modelStep(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                             input bit rdy, input bit rst);
        logic [31:0] a;
        logic [31:0] dropped;
        bit          popped, space;
        a = adr & ~32'h3;
        if (rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_txcnt = 32'h0;
        end else begin
            popped = rdy && (m_q.size() > 0);
            space  = (m_q.size() < 4) || popped;
            if (popped)
                dropped = m_q.pop_front();
            if (we) begin
                if (a < 32'h100) begin
                    m_ram[a[7:2]]       = wd;
                    m_ram_known[a[7:2]] = 1'b1;
                end else if (a == 32'h100) begin
                    if (space) begin
                        m_q.push_back(wd);
                        m_txcnt = m_txcnt + 32'd1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (a == 32'h104) begin
                    m_ovf = 1'b0;
                end
            end
        end
    endtask

    // One clock cycle: drive, compare outputs against the model's current state, then clock.
    task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                                 input bit rdy, input bit rst);
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        tx_ready  = rdy;
        reset     = rst;
        #1;
        if (checking) begin
            if (modelKnown(adr))
                checkOutput("ReadData", ReadData, modelRead(adr));
            checkOutput("tx_valid", {31'b0, tx_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
            checkOutput("tx_data", tx_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
        end
        modelStep(we, adr, wd, rdy, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] adr, input string tag, input logic [31:0] expv);
        MemWrite = 1'b0;
        DataAdr  = adr;
        #1;
        checkOutput(tag, ReadData, expv);
    endtask

    logic [31:0] drain_exp [4];
    logic [31:0] adr;
    bit          we, rdy, rst;

    initial begin
        MemWrite = 0; DataAdr = 0; WriteData = 0; tx_ready = 0; reset = 1;
        m_ovf = 0; m_txcnt = 0;
        for (int i = 0; i < 64; i++) m_ram_known[i] = 1'b0;

        applyStimulus(0, 32'h0, 32'h0, 0, 1);
        applyStimulus(0, 32'h0, 32'h0, 0, 1);
        checking = 1;
        checkOutput("reset_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("reset_data", tx_data, 32'h0);
        peek(32'h104, "reset_status", 32'h2);
        peek(32'h108, "reset_txcount", 32'h0);

        for (int i = 0; i < 64; i++)
            applyStimulus(1, 32'(i * 4), $urandom(), 0, 0);

        applyStimulus(1, 32'd100, 32'd25, 0, 0);
        peek(32'd100, "ram_100", 32'd25);
        applyStimulus(1, 32'd96, 32'd7, 0, 0);
        peek(32'd96, "ram_96", 32'd7);
        peek(32'd100, "ram_100_kept", 32'd25);

        for (int i = 1; i <= 5; i++)
            applyStimulus(1, 32'h100, 32'(i * 32'h11), 0, 0);
        peek(32'h104, "fill_status", 32'h31);
        peek(32'h108, "fill_txcount", 32'd4);
        checkOutput("fill_head", tx_data, 32'h11);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 32'h200, 32'h0, 1, 0);
            if (i < 3)
                checkOutput("drain_data", tx_data, 32'((i + 2) * 32'h11));
            else
                checkOutput("drain_empty", {31'b0, tx_valid}, 32'd0);
        end

        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 32'h100, 32'h60 + 32'(i), 0, 0);
        applyStimulus(1, 32'h100, 32'h99, 1, 0);
        peek(32'h104, "fullpop_status", 32'h31);
        peek(32'h108, "fullpop_txcount", 32'd9);
        drain_exp = '{32'h62, 32'h63, 32'h64, 32'h99};
        for (int i = 0; i < 4; i++) begin
            checkOutput("fullpop_order", tx_data, drain_exp[i]);
            applyStimulus(0, 32'h200, 32'h0, 1, 0);
        end
        checkOutput("fullpop_empty", {31'b0, tx_valid}, 32'd0);
        peek(32'h104, "ovf_still_set", 32'h22);

        applyStimulus(1, 32'h104, 32'hFFFF_FFFF, 0, 0);
        peek(32'h104, "ovf_cleared", 32'h2);
        applyStimulus(1, 32'h200, 32'h1234_5678, 0, 0);
        peek(32'h104, "unmapped_status", 32'h2);
        peek(32'h200, "unmapped_read", 32'h0);
        peek(32'h100, "txdata_read", 32'h0);
        applyStimulus(1, 32'h108, 32'hDEAD_BEEF, 0, 0);
        peek(32'h108, "txcount_ro", 32'd9);

        checkOutput("lat_before", {31'b0, tx_valid}, 32'd0);
        applyStimulus(1, 32'h100, 32'hA5, 0, 0);
        checkOutput("lat_valid", {31'b0, tx_valid}, 32'd1);
        checkOutput("lat_data", tx_data, 32'hA5);

        applyStimulus(0, 32'h0, 32'h0, 0, 1);
        for (int i = 1; i <= 3; i++)
            applyStimulus(1, 32'h100, 32'hB0 + 32'(i), 0, 0);
        peek(32'h108, "mid_txcount", 32'd3);
        peek(32'h104, "mid_status", 32'h0C);
        applyStimulus(1, 32'h100, 32'hCC, 0, 1);
        checkOutput("rst_valid", {31'b0, tx_valid}, 32'd0);
        peek(32'h104, "rst_status", 32'h2);
        peek(32'h108, "rst_txcount", 32'h0);
        peek(32'd100, "rst_ram_kept", 32'd25);

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 5))
                0:       adr = 32'($urandom_range(0, 255));
                1, 2:    adr = 32'h100 | 32'($urandom_range(0, 3));
                3:       adr = 32'h104 | 32'($urandom_range(0, 3));
                4:       adr = 32'h108 | 32'($urandom_range(0, 3));
                default: adr = ($urandom_range(0, 1) == 0) ? 32'h10C : $urandom();
            endcase
            we  = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 99) == 0);
            if (rst)
                we = 1'b0;
            applyStimulus(we, adr, $urandom(), rdy, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
